wb_queue: RTL
=============

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 8, queue entries; power of two, 2..16
- AW, 5, register address width
- DW, 64, result data width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge
- reset, in, 1, asynchronous, active-high reset
- push_valid, in, 1, producer offers a result
- push_ready, out, 1, queue can accept a result
- push_addr, in, AW, destination register
- push_data, in, DW, result value
- hold, in, 1, consumer requests no write this cycle (read slot)
- rf_w, out, 1, register-file write strobe
- rf_wp1, out, AW, write address, port 1 (older entry)
- rf_wp2, out, AW, write address, port 2 (younger entry)
- rf_in1, out, DW, write data, port 1
- rf_in2, out, DW, write data, port 2
- count, out, clog2(DEPTH+1), occupied entries
- empty, out, 1, count==0
REQ-003 Clock and reset SHALL be exactly one clock, clk, and reset, which is asynchronous and active-high.

Function
REQ-004 Queue SHALL be circular FIFO, DEPTH entries of {AW addr, DW data}, with wrapping head/tail pointers.
REQ-005 push_ready SHALL equal (count < DEPTH), from registered count only; same-cycle drain does not raise it.
REQ-006 Push SHALL occur at a rising edge when push_valid && push_ready; entry written at tail, tail+1 mod DEPTH.
REQ-007 Drain SHALL occur at a rising edge when !hold && count>=1; entries present before that edge only (no same-cycle push-to-drain).
REQ-008 count>=2 drain SHALL pop two: oldest to rf_wp1/rf_in1, next to rf_wp2/rf_in2; head+2.
REQ-009 count==1 drain SHALL pop one and drive it on both ports (rf_wp2=rf_wp1, rf_in2=rf_in1); head+1.
REQ-010 rf_w, rf_wp1/2, rf_in1/2 SHALL be registered and update at drain edge; rf_w=1 for exactly one cycle per drain, else 0, with address/data holding last values.
REQ-011 Two popped entries with equal address SHALL keep order (older on port 1, younger on port 2) so port-2 write wins.
REQ-012 Simultaneous push and drain SHALL update count by +1-popped in one edge; never overflow or underflow.
REQ-013 Push into full queue (push_ready=0) SHALL be ignored; drain with hold=1 or count==0 SHALL not move head.
REQ-014 Latency: result pushed at edge E into empty queue, hold=0, SHALL show rf_w=1 after edge E+1.

Reset
REQ-015 reset=1 SHALL immediately set head, tail, count to 0, empty=1, push_ready=1, rf_w=0, rf_wp1/2=0, rf_in1/2=0.
REQ-016 Reset mid-operation SHALL discard all queued entries; no write strobe is issued for them.

Configuration
REQ-017 Macro WBQ_ZERO_DROP_EN defined: push with push_addr==0 SHALL complete handshake (push_ready rules apply) but not enter queue; count unchanged.
REQ-018 WBQ_ZERO_DROP_EN undefined: address-0 results SHALL be queued and written like any other.

Verification
REQ-019 Scenarios a bench SHALL cover:
- Reset, push {3,0xA5} once, hold=0 -> rf_w=1 one cycle after next edge, rf_wp1=rf_wp2=3, rf_in1=rf_in2=0xA5, count back to 0.
- hold=1, push 8 entries addr 1..8 -> push_ready=0, count=8; 9th push ignored; release hold -> 4 drain cycles, pairs (1,2),(3,4),(5,6),(7,8) in order.
- Push {6,0x11} then {6,0x22}, hold=1 then release -> one drain, rf_wp1=rf_wp2=6, rf_in1=0x11, rf_in2=0x22.
- Continuous push every cycle with hold=0 -> count never exceeds 1, one write per cycle, no entry lost across pointer wrap (20 entries).
- Assert reset with count=5 mid-stream -> count=0, rf_w=0 same cycle, no further writes.
- WBQ_ZERO_DROP_EN defined, push {0,0xFF} then {2,0x7} -> only addr 2 written; undefined -> both written.

Source files
------------

// File: rtl/wb_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue_if
// Description : Producer/consumer bundle for the write-back queue: result push
//               handshake, hold request, dual-port register-file write side.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_queue_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 5,
    parameter int DW    = 64
);
    logic                         push_valid;
    logic                         push_ready;
    logic [AW-1:0]                push_addr;
    logic [DW-1:0]                push_data;
    logic                         hold;
    logic                         rf_w;
    logic [AW-1:0]                rf_wp1;
    logic [AW-1:0]                rf_wp2;
    logic [DW-1:0]                rf_in1;
    logic [DW-1:0]                rf_in2;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         empty;

    modport master (
        output push_valid, push_addr, push_data, hold,
        input  push_ready, rf_w, rf_wp1, rf_wp2, rf_in1, rf_in2, count, empty
    );

    modport slave (
        input  push_valid, push_addr, push_data, hold,
        output push_ready, rf_w, rf_wp1, rf_wp2, rf_in1, rf_in2, count, empty
    );
endinterface
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue
// Description : Circular write-back result queue draining up to two entries
//               per cycle into a dual-write-port register file.
//               Optional macro WBQ_ZERO_DROP_EN: address-0 results are accepted
//               but discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 5,
    parameter int DW    = 64
) (
    input  wire logic  clk,
    input  wire logic  reset,
    wb_queue_if.slave  bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [AW-1:0]      r_mem_addr [DEPTH];
    logic [DW-1:0]      r_mem_data [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic               r_rf_w;
    logic [AW-1:0]      r_wp1;
    logic [AW-1:0]      r_wp2;
    logic [DW-1:0]      r_in1;
    logic [DW-1:0]      r_in2;

    logic               w_push_ready;
    logic               w_push_fire;
    logic               w_enq;
    logic               w_drain;
    logic               w_pop_two;
    logic [1:0]         w_pop_cnt;
    logic [c_ptr_w-1:0] w_head_nxt;

    // Readiness looks only at the registered count, so a same-edge drain never
    // opens a slot early.
    assign w_push_ready = (r_count < c_cnt_w'(DEPTH));
    assign w_push_fire  = bus.push_valid && w_push_ready;

`ifdef WBQ_ZERO_DROP_EN
    assign w_enq = w_push_fire && (bus.push_addr != '0);
`else
    assign w_enq = w_push_fire;
`endif

    assign w_drain    = !bus.hold && (r_count != '0);
    assign w_pop_two  = (r_count >= c_cnt_w'(2));
    assign w_pop_cnt  = w_drain ? (w_pop_two ? 2'd2 : 2'd1) : 2'd0;
    assign w_head_nxt = r_head + c_ptr_w'(1);

    // Storage is unreset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_addr[r_tail] <= bus.push_addr;
            r_mem_data[r_tail] <= bus.push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_ptr_w'(1);
            end
            r_head  <= r_head + c_ptr_w'(w_pop_cnt);
            r_count <= r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_pop_cnt);
        end
    end

    // Older entry always lands on port 1 so a same-address port-2 write wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rf_w <= 1'b0;
            r_wp1  <= '0;
            r_wp2  <= '0;
            r_in1  <= '0;
            r_in2  <= '0;
        end else begin
            r_rf_w <= w_drain;
            if (w_drain) begin
                r_wp1 <= r_mem_addr[r_head];
                r_in1 <= r_mem_data[r_head];
                r_wp2 <= w_pop_two ? r_mem_addr[w_head_nxt] : r_mem_addr[r_head];
                r_in2 <= w_pop_two ? r_mem_data[w_head_nxt] : r_mem_data[r_head];
            end
        end
    end

    assign bus.push_ready = w_push_ready;
    assign bus.count      = r_count;
    assign bus.empty      = (r_count == '0);
    assign bus.rf_w       = r_rf_w;
    assign bus.rf_wp1     = r_wp1;
    assign bus.rf_wp2     = r_wp2;
    assign bus.rf_in1     = r_in1;
    assign bus.rf_in2     = r_in2;
endmodule
`default_nettype wire
